// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants for the multicycle controller
package ctrl_pkg;

   // controller states
   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_TRAP   = 3'd5;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   // next-PC source select
   localparam logic [1:0] PC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JAL    = 2'd2;
   localparam logic [1:0] PC_JALR   = 2'd3;

   // register write-back source select
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   // trap causes
   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_IMEM    = 2'd2;
   localparam logic [1:0] CAUSE_DMEM    = 2'd3;

   // major opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU op for the shared R/I arithmetic space; alt selects SUB/SRA
   function automatic logic [3:0] alu_map(input logic alt, input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - ALU operation and illegal-encoding decode
module alu_dec
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   output logic [3:0] alu_op,
   output logic       illegal
);

   // decode the instruction fields into an ALU op and a legality flag
   always_comb begin
      alu_op  = ALU_ADD;
      illegal = 1'b0;
      case (opcode)
         OP_R: begin
            alu_op = alu_map(func7[5], func3);
            if (func7 != 7'b0000000 && func7 != 7'b0100000)
               illegal = 1'b1;
            else if (func7[5] && func3 != 3'b000 && func3 != 3'b101)
               illegal = 1'b1;
         end
         OP_IMM: begin
            // immediates carry no SUB; only the shift-right form uses func7[5]
            alu_op = alu_map((func3 == 3'b101) && func7[5], func3);
         end
         OP_LOAD: begin
            illegal = (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
         end
         OP_STORE: begin
            illegal = (func3 > 3'b010);
         end
         OP_BRANCH: begin
            alu_op  = ALU_SUB;
            illegal = (func3 == 3'b010) || (func3 == 3'b011);
         end
         OP_JALR: begin
            illegal = (func3 != 3'b000);
         end
         OP_LUI: begin
            alu_op = ALU_PASS_B;
         end
         OP_JAL, OP_AUIPC: begin
            alu_op = ALU_ADD;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with memory timeouts
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  func3,
   input  logic [6:0]  func7,
   input  logic        br_taken,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        rf_we,
   output logic        pc_we,
   output logic [3:0]  alu_op,
   output logic [1:0]  pc_sel,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] instret
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

   logic [2:0]    state_nx;
   logic [1:0]    cause_nx;
   logic [CW-1:0] wait_cnt;
   logic [6:0]    op_q;
   logic [2:0]    f3_q;
   logic [6:0]    f7_q;
   logic [6:0]    op_s;
   logic [2:0]    f3_s;
   logic [6:0]    f7_s;
   logic [3:0]    dec_alu_op;
   logic          dec_illegal;
   logic          is_load;
   logic          is_store;
   logic          is_branch;

   // DECODE sees the live IR fields; later states use the copy taken in DECODE
   always_comb begin
      op_s = (state == ST_DECODE) ? opcode : op_q;
      f3_s = (state == ST_DECODE) ? func3  : f3_q;
      f7_s = (state == ST_DECODE) ? func7  : f7_q;
   end

   alu_dec u_alu_dec (
      .opcode  (op_s),
      .func3   (f3_s),
      .func7   (f7_s),
      .alu_op  (dec_alu_op),
      .illegal (dec_illegal)
   );

   // instruction class flags used for sequencing and strobes
   always_comb begin
      is_load   = (op_s == OP_LOAD);
      is_store  = (op_s == OP_STORE);
      is_branch = (op_s == OP_BRANCH);
   end

   // next-state and trap-cause selection; ready wins over a same-cycle timeout
   always_comb begin
      state_nx = state;
      cause_nx = trap_cause;
      case (state)
         ST_FETCH: begin
            if (imem_ready) begin
               state_nx = ST_DECODE;
            end else if (wait_cnt == WAIT_MAX) begin
               state_nx = ST_TRAP;
               cause_nx = CAUSE_IMEM;
            end
         end
         ST_DECODE: begin
            if (dec_illegal) begin
               state_nx = ST_TRAP;
               cause_nx = CAUSE_ILLEGAL;
            end else begin
               state_nx = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_branch)
               state_nx = ST_FETCH;
            else if (is_load || is_store)
               state_nx = ST_MEM;
            else
               state_nx = ST_WB;
         end
         ST_MEM: begin
            if (dmem_ready) begin
               state_nx = is_store ? ST_FETCH : ST_WB;
            end else if (wait_cnt == WAIT_MAX) begin
               state_nx = ST_TRAP;
               cause_nx = CAUSE_DMEM;
            end
         end
         ST_WB:   state_nx = ST_FETCH;
         ST_TRAP: state_nx = ST_TRAP;
         default: state_nx = ST_FETCH;
      endcase
   end

   // state, trap cause, retire counter, wait counter and field capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_FETCH;
         trap_cause <= CAUSE_NONE;
         instret    <= 32'd0;
         wait_cnt   <= '0;
         op_q       <= 7'd0;
         f3_q       <= 3'd0;
         f7_q       <= 7'd0;
      end else begin
         state      <= state_nx;
         trap_cause <= cause_nx;
         // every instruction retires with exactly one pc_we pulse
         if (pc_we)
            instret <= instret + 32'd1;
         if (state_nx != state)
            wait_cnt <= '0;
         else if ((state == ST_FETCH && !imem_ready) || (state == ST_MEM && !dmem_ready))
            wait_cnt <= wait_cnt + CW'(1);
         if (state == ST_DECODE) begin
            op_q <= opcode;
            f3_q <= func3;
            f7_q <= func7;
         end
      end
   end

   // strobes and selects; held low while reset is asserted so nothing commits
   always_comb begin
      imem_req = 1'b0;
      ir_we    = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      alu_op   = ALU_ADD;
      pc_sel   = PC_PLUS4;
      wb_sel   = WB_ALU;
      if (rst_n) begin
         case (state)
            ST_FETCH: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
            end
            ST_DECODE: begin
               alu_op = dec_alu_op;
            end
            ST_EXEC: begin
               alu_op = dec_alu_op;
               if (is_branch) begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
               end
            end
            ST_MEM: begin
               alu_op   = dec_alu_op;
               dmem_req = 1'b1;
               dmem_we  = is_store;
               pc_we    = is_store && dmem_ready;
            end
            ST_WB: begin
               alu_op = dec_alu_op;
               rf_we  = 1'b1;
               pc_we  = 1'b1;
               if (is_load)
                  wb_sel = WB_MEM;
               else if (op_s == OP_JAL || op_s == OP_JALR)
                  wb_sel = WB_PC4;
               else if (op_s == OP_LUI)
                  wb_sel = WB_IMM;
               if (op_s == OP_JAL)
                  pc_sel = PC_JAL;
               else if (op_s == OP_JALR)
                  pc_sel = PC_JALR;
            end
            default: begin
            end
         endcase
      end
   end

   assign trap = (state == ST_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

   localparam int TMO = 16;
   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_LUI = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        br_taken;
   logic        imem_ready;
   logic        dmem_ready;
   logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
   logic [3:0]  alu_op;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  state;
   logic        trap;
   logic [1:0]  trap_cause;
   logic [31:0] instret;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] exp_instret = 32'd0;
   int          arith_ops[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
   logic [6:0]  legal_ops[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

   multicycle_ctrl #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .func3      (func3),
      .func7      (func7),
      .br_taken   (br_taken),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .ir_we      (ir_we),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .rf_we      (rf_we),
      .pc_we      (pc_we),
      .alu_op     (alu_op),
      .pc_sel     (pc_sel),
      .wb_sel     (wb_sel),
      .state      (state),
      .trap       (trap),
      .trap_cause (trap_cause),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // instruction semantics: legality, expected ALU op and class
   function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                      output bit legal, output int aop, output int kind);
      legal = 1'b1;
      aop   = 0;
      kind  = K_ALU;
      case (op)
         7'h33: begin
            aop = arith_ops[f3];
            if (f7 == 7'h20) begin
               if (f3 == 3'd0) aop = 1;
               else if (f3 == 3'd5) aop = 7;
               else legal = 1'b0;
            end else if (f7 != 7'h00) begin
               legal = 1'b0;
            end
         end
         7'h13: begin
            aop = arith_ops[f3];
            if (f3 == 3'd5 && f7[5]) aop = 7;
         end
         7'h03: begin kind = K_LOAD;  legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
         7'h23: begin kind = K_STORE; legal = (f3 <= 3'd2); end
         7'h63: begin kind = K_BR;    aop = 1; legal = !(f3 == 3'd2 || f3 == 3'd3); end
         7'h6F: kind = K_JAL;
         7'h67: begin kind = K_JALR;  legal = (f3 == 3'd0); end
         7'h37: begin kind = K_LUI;   aop = 10; end
         7'h17: kind = K_ALU;
         default: legal = 1'b0;
      endcase
   endfunction

   task automatic trap_hold(input logic [1:0] cause, input int n);
      for (int i = 0; i < n; i++) begin
         imem_ready = 1'($urandom);
         dmem_ready = 1'($urandom);
         #2;
         chk("trap_state", 32'(state), 32'd5);
         chk("trap_flag", 32'(trap), 32'd1);
         chk("trap_cause", 32'(trap_cause), 32'(cause));
         chk("trap_strobes", 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we}), 32'd0);
         chk("trap_instret", instret, exp_instret);
         tick();
      end
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      #2;
      chk("rst_strobes", 32'({ir_we, dmem_req, dmem_we, rf_we, pc_we}), 32'd0);
      tick();
      rst_n = 1'b1;
      imem_ready = 1'b0;
      #2;
      exp_instret = 32'd0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_trap", 32'({trap, trap_cause}), 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd1);
   endtask

   // status: 0 retired, 1 trapped, 2 abandoned by reset
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic br, input int iw, input int dw, input int rst_mem,
                            output int status);
      bit legal;
      int aop;
      int kind;
      int ewb;
      int eps;
      status = 0;
      ref_decode(op, f3, f7, legal, aop, kind);
      opcode = op; func3 = f3; func7 = f7; br_taken = br;
      ewb = (kind == K_LOAD) ? 1 : (kind == K_JAL || kind == K_JALR) ? 2 : (kind == K_LUI) ? 3 : 0;
      eps = (kind == K_JAL) ? 2 : (kind == K_JALR) ? 3 : 0;

      for (int c = 0; c <= TMO; c++) begin
         imem_ready = (c == iw);
         dmem_ready = 1'($urandom);
         #2;
         chk("fetch_state", 32'(state), 32'd0);
         chk("fetch_strobes", 32'({imem_req, ir_we, dmem_req, rf_we, pc_we, trap}),
             32'({1'b1, imem_ready, 4'b0000}));
         tick();
         if (c == iw) break;
      end
      if (iw > TMO) begin
         trap_hold(2'd2, 20);
         status = 1;
         return;
      end

      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      #2;
      chk("dec_state", 32'(state), 32'd1);
      chk("dec_strobes", 32'({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we}), 32'd0);
      tick();
      if (!legal) begin
         trap_hold(2'd1, 20);
         status = 1;
         return;
      end

      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      #2;
      chk("exec_state", 32'(state), 32'd2);
      chk("exec_alu_op", 32'(alu_op), 32'(aop));
      if (kind == K_BR) begin
         chk("exec_branch", 32'({pc_we, pc_sel, rf_we, dmem_req}), 32'({1'b1, br ? 2'd1 : 2'd0, 2'b00}));
         tick();
         exp_instret++;
         chk("br_instret", instret, exp_instret);
         return;
      end
      chk("exec_strobes", 32'({pc_we, rf_we, dmem_req}), 32'd0);
      tick();

      if (kind == K_LOAD || kind == K_STORE) begin
         for (int c = 0; c <= TMO; c++) begin
            dmem_ready = (c == dw);
            imem_ready = 1'($urandom);
            if (c == rst_mem) begin
               rst_n = 1'b0;
               dmem_ready = 1'b1;
            end
            #2;
            chk("mem_state", 32'(state), 32'd3);
            if (c == rst_mem) begin
               chk("rstmem_strobes", 32'({rf_we, pc_we}), 32'd0);
               tick();
               rst_n = 1'b1;
               dmem_ready = 1'b0;
               #2;
               exp_instret = 32'd0;
               chk("rstmem_state", 32'(state), 32'd0);
               chk("rstmem_instret", instret, 32'd0);
               chk("rstmem_after", 32'({imem_req, pc_we, rf_we}), 32'b100);
               status = 2;
               return;
            end
            chk("mem_alu_op", 32'(alu_op), 32'd0);
            chk("mem_strobes", 32'({dmem_req, dmem_we, pc_we, rf_we, imem_req, pc_sel}),
                32'({1'b1, kind == K_STORE, (kind == K_STORE) && dmem_ready, 4'b0000}));
            tick();
            if (c == dw) break;
         end
         if (dw > TMO) begin
            trap_hold(2'd3, 20);
            status = 1;
            return;
         end
         if (kind == K_STORE) begin
            exp_instret++;
            chk("st_instret", instret, exp_instret);
            return;
         end
      end

      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      #2;
      chk("wb_state", 32'(state), 32'd4);
      chk("wb_strobes", 32'({rf_we, pc_we, imem_req, dmem_req, dmem_we}), 32'b11000);
      chk("wb_sel", 32'(wb_sel), 32'(ewb));
      chk("wb_pc_sel", 32'(pc_sel), 32'(eps));
      chk("wb_alu_op", 32'(alu_op), 32'(aop));
      tick();
      exp_instret++;
      chk("wb_instret", instret, exp_instret);
   endtask

   initial begin
      int st;
      logic [6:0] op;
      logic [6:0] f7;
      int iw;
      int dw;
      rst_n = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
      br_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      do_reset();

      run_instr(7'h33, 3'd0, 7'h00, 1'b0, 2, 0, -1, st);   // ADD x3,x1,x2
      chk("add_instret", instret, 32'd1);
      run_instr(7'h03, 3'd2, 7'h00, 1'b0, 0, 3, -1, st);   // LW
      run_instr(7'h63, 3'd0, 7'h00, 1'b1, 0, 0, -1, st);   // BEQ taken
      run_instr(7'h23, 3'd2, 7'h00, 1'b0, 1, 1, -1, st);   // SW
      run_instr(7'h13, 3'd5, 7'h20, 1'b0, TMO, 0, -1, st); // SRAI, ready on the limit cycle
      run_instr(7'h33, 3'd5, 7'h20, 1'b0, 0, 0, -1, st);   // SRA
      run_instr(7'h6F, 3'd3, 7'h11, 1'b0, 0, 0, -1, st);   // JAL
      run_instr(7'h03, 3'd4, 7'h00, 1'b0, 0, TMO, -1, st); // LBU, ready on the limit cycle
      run_instr(7'h7F, 3'd0, 7'h00, 1'b0, 0, 0, -1, st);   // illegal opcode
      do_reset();
      run_instr(7'h13, 3'd0, 7'h00, 1'b0, TMO + 1, 0, -1, st); // fetch timeout
      do_reset();
      run_instr(7'h03, 3'd0, 7'h00, 1'b0, 0, TMO + 1, -1, st); // load timeout
      do_reset();
      run_instr(7'h23, 3'd2, 7'h00, 1'b0, 0, 10, 2, st);   // reset during SW MEM

      for (int n = 0; n < 200; n++) begin
         int k;
         k  = $urandom_range(0, 9);
         op = (k < 9) ? legal_ops[k] : 7'($urandom);
         case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         iw = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3);
         dw = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3);
         run_instr(op, 3'($urandom), f7, 1'($urandom), iw, dw,
                   ($urandom_range(0, 19) == 0) ? 0 : -1, st);
         if (st == 1) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
